// File: rtl/sd_data_rx_deser.sv
// SD receive deserializer: detects start bit, packs DAT payload into 32-bit words, checks per-line CRC16.
// Latency: wr_o/dat_o appear the cycle after a word's last bit; done the cycle after the final end bit.
// Backpressure: none; the consumer must take one wr_o every 8 sd_clk cycles in 4-bit mode.
module sd_data_rx_deser #(
  parameter int          BLKSIZE_W = 12,
  parameter int          BLKCNT_W  = 16,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 start_rx,
  input  logic                 stop_rx,
  input  logic                 bus_4bit,
  input  logic [BLKSIZE_W-1:0] blksize,
  input  logic [BLKCNT_W-1:0]  blkcnt,
  input  logic [3:0]           dat_i,
  output logic                 wr_o,
  output logic [31:0]          dat_o,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_err,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT_START, ST_DATA, ST_CRC, ST_END} state_t;

  localparam logic [BLKSIZE_W-1:0] BYTE_ONE = {{(BLKSIZE_W-1){1'b0}}, 1'b1};
  localparam logic [BLKCNT_W-1:0]  BLK_ONE  = {{(BLKCNT_W-1){1'b0}}, 1'b1};

  state_t                 state, state_nxt;
  logic                   mode4;
  logic [BLKSIZE_W-1:0]   blksize_q, byte_cnt;
  logic [BLKCNT_W-1:0]    blkcnt_q, blk_cnt;
  logic [15:0]            tmo_cnt;
  logic [2:0]             sub_cnt;
  logic [1:0]             byte_in_word;
  logic [3:0]             crc_cnt;
  logic [31:0]            word_sr, word_nxt;
  logic [3:0][15:0]       crc_q;
  logic [3:0]             crc_msb;
  logic                   start_ok, start_bit, tmo_hit, byte_end, last_byte, word_end;
  logic                   crc_mism, end_err, blk_last;

  // One MSB-first step of CRC16 with polynomial 0x1021
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic b);
    crc16_upd = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign busy = (state != ST_IDLE);

  // Decode of per-cycle events used by both the FSM and the datapath
  always_comb begin
    start_ok  = (state == ST_IDLE) && start_rx && !stop_rx;
    start_bit = mode4 ? (dat_i == 4'h0) : !dat_i[0];
    tmo_hit   = !start_bit && (tmo_cnt == TIMEOUT - 16'd1);
    byte_end  = (state == ST_DATA) && (mode4 ? sub_cnt[0] : (sub_cnt == 3'd7));
    last_byte = byte_end && ((byte_cnt + BYTE_ONE) == blksize_q);
    word_end  = byte_end && ((byte_in_word == 2'd3) || last_byte);
    word_nxt  = mode4 ? {word_sr[27:0], dat_i} : {word_sr[30:0], dat_i[0]};
    crc_msb   = {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]};
    crc_mism  = mode4 ? |(dat_i ^ crc_msb) : (dat_i[0] ^ crc_msb[0]);
    end_err   = !dat_i[0];
    blk_last  = ((blk_cnt + BLK_ONE) == blkcnt_q);
  end

  // State register
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; an abort overrides every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (start_ok) state_nxt = ST_WAIT_START;
      ST_WAIT_START: if (start_bit) state_nxt = ST_DATA;
                     else if (tmo_hit) state_nxt = ST_IDLE;
      ST_DATA:       if (last_byte) state_nxt = ST_CRC;
      ST_CRC:        if (crc_cnt == 4'd15) state_nxt = ST_END;
      ST_END:        state_nxt = (crc_err || end_err || blk_last) ? ST_IDLE : ST_WAIT_START;
      default:       state_nxt = ST_IDLE;
    endcase
    if (stop_rx && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  // Datapath: configuration capture, counters, word packing, CRC and status flags
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      mode4        <= 1'b0;
      blksize_q    <= '0;
      blkcnt_q     <= '0;
      blk_cnt      <= '0;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      sub_cnt      <= '0;
      byte_in_word <= '0;
      crc_cnt      <= '0;
      word_sr      <= '0;
      crc_q        <= '0;
      wr_o         <= 1'b0;
      dat_o        <= '0;
      done         <= 1'b0;
      crc_err      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      wr_o <= 1'b0;
      done <= 1'b0;
      if (stop_rx) begin
        // Abort: flags held, any word completing now is dropped
        if (state != ST_IDLE) done <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (start_rx) begin
            mode4       <= bus_4bit;
            blksize_q   <= blksize;
            blkcnt_q    <= (blkcnt == '0) ? BLK_ONE : blkcnt;
            blk_cnt     <= '0;
            tmo_cnt     <= '0;
            crc_err     <= 1'b0;
            timeout_err <= 1'b0;
          end
          ST_WAIT_START: begin
            if (start_bit) begin
              byte_cnt     <= '0;
              sub_cnt      <= '0;
              byte_in_word <= '0;
              crc_cnt      <= '0;
              crc_q        <= '0;
            end else if (tmo_hit) begin
              timeout_err <= 1'b1;
              done        <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
          ST_DATA: begin
            word_sr <= word_nxt;
            for (int i = 0; i < 4; i++) crc_q[i] <= crc16_upd(crc_q[i], dat_i[i]);
            sub_cnt <= byte_end ? 3'd0 : sub_cnt + 3'd1;
            if (byte_end) begin
              byte_cnt     <= byte_cnt + BYTE_ONE;
              byte_in_word <= byte_in_word + 2'd1;
            end
            if (word_end) begin
              // Left-align a partial final word so unfilled low bytes read as zero
              wr_o  <= 1'b1;
              dat_o <= word_nxt << {~byte_in_word, 3'b000};
            end
          end
          ST_CRC: begin
            crc_cnt <= crc_cnt + 4'd1;
            if (crc_mism) crc_err <= 1'b1;
            for (int i = 0; i < 4; i++) crc_q[i] <= {crc_q[i][14:0], 1'b0};
          end
          ST_END: begin
            if (end_err) crc_err <= 1'b1;
            if (crc_err || end_err || blk_last) begin
              done <= 1'b1;
            end else begin
              blk_cnt <= blk_cnt + BLK_ONE;
              tmo_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_data_rx_deser.sv
// Directed bench for sd_data_rx_deser: table of single-block transfers plus multi-cycle corner sequences.
// Latency: words and done are collected by a negedge monitor and compared with bench-built expectations.
// Backpressure: none exists; the bench only observes wr_o spacing.
module tb_sd_data_rx_deser;
  localparam int BW = 12;
  localparam int CW = 16;

  logic          sd_clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_rx = 1'b0;
  logic          stop_rx = 1'b0;
  logic          bus_4bit = 1'b0;
  logic [BW-1:0] blksize = '0;
  logic [CW-1:0] blkcnt = '0;
  logic [3:0]    dat_i = 4'hF;
  logic          wr_o;
  logic [31:0]   dat_o;
  logic          busy, done, crc_err, timeout_err;

  sd_data_rx_deser #(.BLKSIZE_W(BW), .BLKCNT_W(CW), .TIMEOUT(16'd100)) dut (
    .sd_clk(sd_clk), .rst(rst), .start_rx(start_rx), .stop_rx(stop_rx), .bus_4bit(bus_4bit),
    .blksize(blksize), .blkcnt(blkcnt), .dat_i(dat_i), .wr_o(wr_o), .dat_o(dat_o),
    .busy(busy), .done(done), .crc_err(crc_err), .timeout_err(timeout_err)
  );

  always #5 sd_clk = ~sd_clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          wr_cyc[$];
  logic [7:0]  pay [512];
  logic        use_fixed = 1'b0;
  logic [15:0] fixed_crc = 16'h0;

  typedef struct {
    logic        m4;
    int          n;
    logic [63:0] b;
    logic [CW-1:0] bc;
    int          flip;
    logic        endb;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
  } vec_t;
  vec_t vt[6];

  always @(posedge sd_clk) cyc++;

  // Output monitor, sampling away from the active edge
  always @(negedge sd_clk) begin
    if (wr_o) begin
      got_q.push_back(dat_o);
      wr_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic idle(input int n);
    dat_i = 4'hF;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start_rx = 1'b1;
    step();
    start_rx = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int max, input string nm);
    int k = 0;
    while (done_cnt == d0 && k < max) begin
      @(negedge sd_clk);
      #1;
      k++;
    end
    chk(nm, {31'b0, done_cnt != d0}, 32'd1);
  endtask

  task automatic build_exp(input int n);
    for (int i = 0; i < n; i += 4) begin
      logic [31:0] w = '0;
      for (int j = 0; j < 4; j++)
        if (i + j < n) w[31-8*j -: 8] = pay[i+j];
      exp_q.push_back(w);
    end
  endtask

  function automatic int word_mism();
    int m = 0;
    if (got_q.size() != exp_q.size()) return -1;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  // Drive one block: start bit, payload, CRC16 per line, end bit.
  // stop_byte >= 0 aborts before that byte; rst_bit >= 0 asserts reset before that CRC bit.
  task automatic send_block(input logic m4, input int n, input int flip_line, input logic endb,
                            input int stop_byte, input int rst_bit);
    logic [15:0] c [4];
    logic [3:0]  nib;
    for (int l = 0; l < 4; l++) c[l] = 16'h0;
    dat_i = m4 ? 4'h0 : 4'hE;
    step();
    for (int i = 0; i < n; i++) begin
      if (i == stop_byte) begin
        stop_rx = 1'b1;
        step();
        stop_rx = 1'b0;
        dat_i = 4'hF;
        return;
      end
      if (m4) begin
        for (int h = 0; h < 2; h++) begin
          nib = (h == 0) ? pay[i][7:4] : pay[i][3:0];
          dat_i = nib;
          for (int l = 0; l < 4; l++) c[l] = crc_step(c[l], nib[l]);
          step();
        end
      end else begin
        for (int k = 7; k >= 0; k--) begin
          dat_i = {3'b111, pay[i][k]};
          c[0] = crc_step(c[0], pay[i][k]);
          step();
        end
      end
    end
    if (use_fixed) c[0] = fixed_crc;
    if (flip_line >= 0) c[flip_line][15] = ~c[flip_line][15];
    for (int k = 15; k >= 0; k--) begin
      if (k == rst_bit) begin
        rst = 1'b1;
        return;
      end
      dat_i = m4 ? {c[3][k], c[2][k], c[1][k], c[0][k]} : {3'b111, c[0][k]};
      step();
    end
    dat_i = {3'b111, endb};
    step();
    dat_i = 4'hF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, c0, gaps;

    vt[0] = '{1'b0, 4, 64'hDEADBEEF_00000000, 16'd1, -1, 1'b1, 1, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[1] = '{1'b1, 5, 64'h01234567_89000000, 16'd1, -1, 1'b1, 2, 32'h01234567, 32'h89000000, 1'b0};
    vt[2] = '{1'b0, 2, 64'hA55A0000_00000000, 16'd1, -1, 1'b0, 1, 32'hA55A0000, 32'h0, 1'b1};
    vt[3] = '{1'b1, 3, 64'hC0FFEE00_00000000, 16'd1,  3, 1'b1, 1, 32'hC0FFEE00, 32'h0, 1'b1};
    vt[4] = '{1'b1, 1, 64'h7E000000_00000000, 16'd0, -1, 1'b1, 1, 32'h7E000000, 32'h0, 1'b0};
    vt[5] = '{1'b0, 8, 64'h00010203_04050607, 16'd1, -1, 1'b1, 2, 32'h00010203, 32'h04050607, 1'b0};

    // Reset state
    #2;
    chk("rst_wr_o", {31'b0, wr_o}, 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    chk("rst_flags", {28'b0, busy, done, crc_err, timeout_err}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Table of single-block transfers
    for (int v = 0; v < 6; v++) begin
      bus_4bit = vt[v].m4;
      blksize  = BW'(vt[v].n);
      blkcnt   = vt[v].bc;
      for (int i = 0; i < 8; i++) pay[i] = vt[v].b[63-8*i -: 8];
      got_q.delete();
      d0 = done_cnt;
      pulse_start();
      idle(2);
      send_block(vt[v].m4, vt[v].n, vt[v].flip, vt[v].endb, -1, -1);
      wait_done(d0, 40, $sformatf("v%0d_done_seen", v));
      idle(4);
      chk($sformatf("v%0d_nwords", v), 32'(got_q.size()), 32'(vt[v].nw));
      chk($sformatf("v%0d_w0", v), (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx, vt[v].w0);
      if (vt[v].nw > 1)
        chk($sformatf("v%0d_w1", v), (got_q.size() > 1) ? got_q[1] : 32'hxxxxxxxx, vt[v].w1);
      chk($sformatf("v%0d_crc_err", v), {31'b0, crc_err}, {31'b0, vt[v].err});
      chk($sformatf("v%0d_tmo_err", v), {31'b0, timeout_err}, 32'd0);
      chk($sformatf("v%0d_busy", v), {31'b0, busy}, 32'd0);
      chk($sformatf("v%0d_done_cnt", v), 32'(done_cnt - d0), 32'd1);
    end

    // ASCII "123456789" in 1-bit mode with its known CRC 0x31C3
    bus_4bit = 1'b0; blksize = 12'd9; blkcnt = 16'd1;
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    use_fixed = 1'b1; fixed_crc = 16'h31C3;
    got_q.delete();
    d0 = done_cnt;
    pulse_start();
    idle(3);
    send_block(1'b0, 9, -1, 1'b1, -1, -1);
    use_fixed = 1'b0;
    wait_done(d0, 40, "ascii_done_seen");
    idle(5);
    chk("ascii_nwords", 32'(got_q.size()), 32'd3);
    chk("ascii_w0", (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx, 32'h31323334);
    chk("ascii_w1", (got_q.size() > 1) ? got_q[1] : 32'hxxxxxxxx, 32'h35363738);
    chk("ascii_w2", (got_q.size() > 2) ? got_q[2] : 32'hxxxxxxxx, 32'h39000000);
    chk("ascii_crc_err", {31'b0, crc_err}, 32'd0);
    chk("ascii_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("ascii_busy", {31'b0, busy}, 32'd0);

    // Timeout: DAT held high, done expected exactly 100 cycles after entering WAIT_START
    got_q.delete();
    dat_i = 4'hF;
    d0 = done_cnt;
    pulse_start();
    c0 = cyc;
    wait_done(d0, 150, "tmo_done_seen");
    chk("tmo_cycle", 32'(done_cyc - c0), 32'd100);
    chk("tmo_err", {31'b0, timeout_err}, 32'd1);
    chk("tmo_nwords", 32'(got_q.size()), 32'd0);
    chk("tmo_busy", {31'b0, busy}, 32'd0);

    // 4-bit, 512 bytes x 2 blocks, random payload
    bus_4bit = 1'b1; blksize = 12'd512; blkcnt = 16'd2;
    got_q.delete(); wr_cyc.delete(); exp_q.delete();
    d0 = done_cnt;
    pulse_start();
    chk("start_clr_tmo", {31'b0, timeout_err}, 32'd0);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
      build_exp(512);
      idle(3);
      send_block(1'b1, 512, -1, 1'b1, -1, -1);
    end
    wait_done(d0, 40, "m4_done_seen");
    idle(4);
    gaps = 0;
    for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 8) gaps++;
    chk("m4_nwords", 32'(got_q.size()), 32'd256);
    chk("m4_words", 32'(word_mism()), 32'd0);
    chk("m4_gaps", 32'(gaps), 32'd1);
    chk("m4_crc_err", {31'b0, crc_err}, 32'd0);
    chk("m4_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Same, with one CRC bit flipped on DAT2 in block 1
    got_q.delete(); exp_q.delete();
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
    build_exp(512);
    idle(3);
    send_block(1'b1, 512, 2, 1'b1, -1, -1);
    wait_done(d0, 40, "flip_done_seen");
    idle(3);
    send_block(1'b1, 512, -1, 1'b1, -1, -1);
    idle(4);
    chk("flip_nwords", 32'(got_q.size()), 32'd128);
    chk("flip_words", 32'(word_mism()), 32'd0);
    chk("flip_crc_err", {31'b0, crc_err}, 32'd1);
    chk("flip_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("flip_busy", {31'b0, busy}, 32'd0);

    // Next start clears crc_err; async reset mid-CRC
    bus_4bit = 1'b0; blksize = 12'd4; blkcnt = 16'd1;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    pulse_start();
    chk("start_clr_crc", {31'b0, crc_err}, 32'd0);
    idle(2);
    send_block(1'b0, 4, -1, 1'b1, -1, 8);
    #1;
    chk("arst_wr_o", {31'b0, wr_o}, 32'd0);
    chk("arst_dat_o", dat_o, 32'd0);
    chk("arst_flags", {28'b0, busy, done, crc_err, timeout_err}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3; pay[3] = 8'hD4;
    got_q.delete();
    d0 = done_cnt;
    pulse_start();
    idle(2);
    send_block(1'b0, 4, -1, 1'b1, -1, -1);
    wait_done(d0, 40, "post_rst_done_seen");
    idle(3);
    chk("post_rst_nwords", 32'(got_q.size()), 32'd1);
    chk("post_rst_w0", (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx, 32'hA1B2C3D4);
    chk("post_rst_crc_err", {31'b0, crc_err}, 32'd0);

    // stop_rx 3 bytes into word 5; an earlier start_rx with other settings is ignored while busy
    bus_4bit = 1'b1; blksize = 12'd64; blkcnt = 16'd1;
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    got_q.delete(); exp_q.delete();
    build_exp(16);
    d0 = done_cnt;
    pulse_start();
    idle(2);
    bus_4bit = 1'b0; blksize = 12'd2;
    pulse_start();
    bus_4bit = 1'b1; blksize = 12'd64;
    chk("stop_busy_after_ignored_start", {31'b0, busy}, 32'd1);
    send_block(1'b1, 64, -1, 1'b1, 19, -1);
    wait_done(d0, 5, "stop_done_seen");
    chk("stop_busy", {31'b0, busy}, 32'd0);
    idle(30);
    chk("stop_nwords", 32'(got_q.size()), 32'd4);
    chk("stop_words", 32'(word_mism()), 32'd0);
    chk("stop_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("stop_crc_err", {31'b0, crc_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_data_rx_deser.md
Name: sd_data_rx_deser

Overview:
Receive-side deserializer of the SD data path. Runs on the card clock and samples the DAT lines in 1-bit or 4-bit mode. For each block it detects the start bit, packs the payload into 32-bit words and checks the per-line CRC16. Each completed word is presented as a single-cycle write strobe (wr_o/dat_o) directly to the RX FIFO filler stage, which carries the words onto Wishbone.

Parameters:
BLKSIZE_W, 12, width of block-size field in bytes (max 4095 bytes per block)
BLKCNT_W, 16, width of block-count field
TIMEOUT, 16'hFFFF, sd_clk cycles to wait for a start bit before declaring timeout

Ports:
sd_clk  in  1  card clock; all logic on rising edge
rst  in  1  asynchronous active-high reset
start_rx  in  1  one-cycle pulse: begin a multi-block read
stop_rx  in  1  abort: return to IDLE next cycle, no further wr_o
bus_4bit  in  1  1 = DAT[3:0] active, 0 = DAT0 only; sampled at start_rx
blksize  in  BLKSIZE_W  bytes per block (must be >=1); sampled at start_rx
blkcnt  in  BLKCNT_W  number of blocks (0 treated as 1); sampled at start_rx
dat_i  in  4  DAT lines from pads (already registered)
wr_o  out  1  one-cycle pulse: dat_o valid for FIFO write
dat_o  out  32  packed word, first received byte in [31:24]
busy  out  1  high from start_rx accepted until return to IDLE
done  out  1  one-cycle pulse after final block end bit or abort
crc_err  out  1  sticky: CRC mismatch or end bit 0; cleared on accepted start_rx
timeout_err  out  1  sticky: no start bit within TIMEOUT; cleared on accepted start_rx

Behaviour:
- Reset (async): state IDLE; wr_o, busy, done, crc_err, timeout_err = 0; dat_o = 0; all counters and CRC registers = 0.
- States: IDLE, WAIT_START, DATA, CRC, END.
- IDLE: start_rx latches bus_4bit, blksize and blkcnt; clears both error flags; goes to WAIT_START; busy = 1 from the next cycle. start_rx is ignored while busy.
- WAIT_START: start bit = DAT0 sampled 0 (in 4-bit mode all four lines 0). Start bit -> DATA with byte/bit counters and the four CRCs zeroed. Timeout counter reaching TIMEOUT -> timeout_err = 1, done pulse, IDLE.
- DATA:
  - 1-bit mode: one bit per cycle, MSB first, byte = 8 cycles.
  - 4-bit mode: DAT[3:0] is one nibble per cycle, high nibble first, byte = 2 cycles.
  - Each line feeds its own CRC16 (poly 0x1021, init 0x0000, MSB first); only DAT0's CRC is used in 1-bit mode.
  - After the 4th byte of a word, or the last byte of the block: wr_o pulses for one cycle in the following cycle, with dat_o holding the word. Unfilled low bytes of a partial final word are 0.
  - After blksize bytes -> CRC.
- CRC: 16 cycles. Each active line's received bits, MSB first, are compared with its computed CRC. Any mismatch sets crc_err.
- END: one cycle; sample end bit, and DAT0 = 0 sets crc_err.
  - If crc_err is set, or blocks received == blkcnt: done pulse, IDLE.
  - Otherwise: increment block counter, clear timeout counter, go to WAIT_START.
- stop_rx (any non-IDLE state):
  - IDLE next cycle, done pulse; a pending wr_o in that same cycle is suppressed.
  - Error flags are held.
  - stop_rx has priority over all simultaneous events.
- start_rx and stop_rx together in IDLE: stop_rx wins, start ignored.
- Counters: the byte counter is BLKSIZE_W bits and compares against blksize with no wrap. The block counter is BLKCNT_W bits.
- Throughput: 4-bit mode gives one word per 8 cycles, so the downstream FIFO must accept a wr_o at least every 8 cycles. No backpressure exists.

Test Plan:
- 1-bit mode, blksize=9, blkcnt=1, payload ASCII "123456789" then CRC 0x31C3 and end bit 1 -> wr_o data 0x31323334, 0x35363738, 0x39000000; crc_err=0; single done pulse; busy drops.
- 4-bit mode, blksize=512, blkcnt=2, random data with correct per-line CRCs -> exactly 256 wr_o pulses with matching words, spaced 8 cycles apart within each block; crc_err=0; done after second end bit.
- Same as previous but flip one CRC bit on DAT2 in block 1 -> 128 wr_o pulses, crc_err=1, done pulse, no block-2 words; next start_rx clears crc_err.
- DAT held high after start_rx with TIMEOUT=100 -> timeout_err=1 and done on cycle 100 after entering WAIT_START; wr_o never pulses.
- stop_rx mid-DATA, 3 bytes into word 5 -> IDLE next cycle, no 5th wr_o, done pulse; start_rx pulsed while busy earlier is shown ignored.
- Assert rst mid-CRC -> all outputs 0 immediately (asynchronous); after release, a new start_rx completes a normal 4-byte block.
